// File: rtl/svm_sequencer_pkg.sv
// Shared constants, state encoding and score helpers for the SVM sequencer.
// Scores are signed fixed point with FRAC_W fractional bits.
package svm_sequencer_pkg;

    localparam int N_FEAT        = 60;
    localparam int FEAT_W        = 16;
    localparam int SCORE_W       = 22;
    localparam int FRAC_W        = 13;
    localparam int SCORE_DLY_DEF = 2;
    localparam int TIMEOUT_DEF   = 32;
    localparam int CNT_W         = $clog2(N_FEAT);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        WAIT_FLAG,
        WAIT_SCORE,
        HOLD
    } state_t;

    function automatic logic score_detect(input logic [SCORE_W-1:0] score,
                                          input logic [SCORE_W-1:0] thr);
        return ($signed(score) >= $signed(thr));
    endfunction

endpackage

// File: rtl/svm_feat_reader.sv
// Walks the feature RAM for one vector and turns the read strobes into a
// contiguous, registered feature burst two cycles behind the reads.
module svm_feat_reader
    import svm_sequencer_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_go,
    input  logic [ADDR_W-1:0] base,
    output logic              rd_last,
    output logic              pipe_busy,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [FEAT_W-1:0] ram_rdata,
    output logic [FEAT_W-1:0] features,
    output logic              flag_valid_features
);

    logic [CNT_W-1:0] k;
    logic [2:1]       vld_pipe;

    always_ff @(posedge clk) begin
        if (rst || !rd_go) begin
            k <= '0;
        end else begin
            k <= k + CNT_W'(1);
        end
    end

    // Stage 1 marks RAM data arriving, stage 2 marks it registered on features.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            features <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], rd_go};
            if (vld_pipe[1]) begin
                features <= ram_rdata;
            end
        end
    end

    assign rd_last             = rd_go && (k == CNT_W'(N_FEAT - 1));
    assign ram_rd_en           = rd_go;
    assign ram_addr            = rd_go ? base + ADDR_W'(k) : '0;
    assign pipe_busy           = vld_pipe[1];
    assign flag_valid_features = vld_pipe[2];

endmodule

// File: rtl/svm_sequencer.sv
// Candidate sequencer for the linear SVM: reads a feature vector, streams it,
// waits for the SVM completion, thresholds the score and holds one result.
module svm_sequencer
    import svm_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int ID_W      = 8,
    parameter int SCORE_DLY = SCORE_DLY_DEF,
    parameter int TIMEOUT   = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cand_valid,
    output logic               cand_ready,
    input  logic [ID_W-1:0]    cand_id,
    input  logic [ADDR_W-1:0]  cand_base,
    output logic               ram_rd_en,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [FEAT_W-1:0]  ram_rdata,
    output logic [FEAT_W-1:0]  features,
    output logic               flag_valid_features,
    input  logic [SCORE_W-1:0] acc_svm_out,
    input  logic               flag_valid_out,
    input  logic [SCORE_W-1:0] cfg_threshold,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [ID_W-1:0]    res_id,
    output logic [SCORE_W-1:0] res_score,
    output logic               res_detect,
    output logic               busy,
    output logic               timeout_err
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam int DCNT_W = $clog2(SCORE_DLY + 1);

    state_t             state, nstate;
    logic [ID_W-1:0]    id_q;
    logic [ADDR_W-1:0]  base_q;
    logic [SCORE_W-1:0] thr_q;
    logic [TCNT_W-1:0]  tcnt;
    logic [DCNT_W-1:0]  dcnt;
    logic               rd_last;
    logic               pipe_busy;
    logic               expire;

    svm_feat_reader #(.ADDR_W(ADDR_W)) u_reader (
        .clk                 (clk),
        .rst                 (rst),
        .rd_go               (state == READ),
        .base                (base_q),
        .rd_last             (rd_last),
        .pipe_busy           (pipe_busy),
        .ram_rd_en           (ram_rd_en),
        .ram_addr            (ram_addr),
        .ram_rdata           (ram_rdata),
        .features            (features),
        .flag_valid_features (flag_valid_features)
    );

    // A completion arriving on the expiry cycle wins over the timeout.
    assign expire = (state == WAIT_FLAG) && !flag_valid_out &&
                    (tcnt == TCNT_W'(TIMEOUT - 1));

    always_comb begin
        nstate = state;
        case (state)
            IDLE:       if (cand_valid)      nstate = READ;
            READ:       if (rd_last)         nstate = DRAIN;
            DRAIN:      if (!pipe_busy)      nstate = WAIT_FLAG;
            WAIT_FLAG:  if (flag_valid_out)  nstate = WAIT_SCORE;
                        else if (expire)     nstate = IDLE;
            WAIT_SCORE: if (dcnt == DCNT_W'(1)) nstate = HOLD;
            HOLD:       if (res_ready)       nstate = IDLE;
            default:                         nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            id_q        <= '0;
            base_q      <= '0;
            thr_q       <= '0;
            tcnt        <= '0;
            dcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= nstate;
            if (state == IDLE && cand_valid) begin
                id_q   <= cand_id;
                base_q <= cand_base;
                thr_q  <= cfg_threshold;
            end
            if (state == DRAIN) begin
                tcnt <= '0;
            end else if (state == WAIT_FLAG) begin
                tcnt <= tcnt + TCNT_W'(1);
            end
            if (expire) begin
                timeout_err <= 1'b1;
            end
            if (state == WAIT_FLAG) begin
                dcnt <= DCNT_W'(SCORE_DLY);
            end else if (state == WAIT_SCORE) begin
                dcnt <= dcnt - DCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_score  <= '0;
            res_detect <= 1'b0;
        end else if (state == WAIT_SCORE && dcnt == DCNT_W'(1)) begin
            res_valid  <= 1'b1;
            res_id     <= id_q;
            res_score  <= acc_svm_out;
            res_detect <= score_detect(acc_svm_out, thr_q);
        end else if (state == HOLD && res_ready) begin
            res_valid  <= 1'b0;
        end
    end

    assign cand_ready = (state == IDLE) && !rst;
    assign busy       = (state != IDLE);

endmodule
